// File: rtl/rv32im_defs.sv
// rv32im_defs: shared constants for the RV32IM pipeline front end
package rv32im_defs;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [1:0] ST_REQ = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: one-entry PC+instruction skid register
module fetch_hold_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      pc <= '0;
      instr <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc <= load_pc;
      instr <= load_instr;
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and instruction fetch front end feeding IF/ID
module if_fetch_unit import rv32im_defs::*; #(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_valid
);
  logic [1:0] state;
  logic [31:0] pc, drain_addr, pending_target, hold_pc, hold_instr, target;
  logic hold_valid, done, hold_load, hold_clear, dlv_req, dlv_hold, out_load, out_valid;
  assign target = branch_target & ~32'h3;
  assign imem_read = state != ST_HOLD;
  // an in-flight miss cannot be aborted, so DRAIN keeps presenting its address
  assign imem_address = state == ST_DRAIN ? drain_addr : pc;
  assign done = imem_read & ~imem_busywait;
  assign dlv_req = state == ST_REQ && done;
  assign dlv_hold = state == ST_HOLD && hold_valid;
  assign hold_load = dlv_req && stall && !branch_taken;
  assign hold_clear = state == ST_HOLD && (branch_taken || !stall);
  assign out_load = reset | branch_taken | ~stall;
  assign out_valid = ~reset & ~branch_taken & (dlv_req | dlv_hold);
  fetch_hold_buffer u_hold (
    .clk(clk),
    .rst(reset),
    .load(hold_load),
    .clear(hold_clear),
    .load_pc(pc),
    .load_instr(imem_readdata),
    .pc(hold_pc),
    .instr(hold_instr),
    .valid(hold_valid)
  );
  always_ff @(posedge clk) begin
    if (out_load) begin
      if_valid <= out_valid;
      if_pc <= !out_valid ? 32'h0 : dlv_hold ? hold_pc : pc;
      if_instruction <= !out_valid ? NOP : dlv_hold ? hold_instr : imem_readdata;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_REQ;
      pc <= RESET_VECTOR;
      drain_addr <= '0;
      pending_target <= '0;
    end else begin
      case (state)
        ST_REQ:
          if (done) begin
            pc <= branch_taken ? target : pc + 32'd4;
            state <= hold_load ? ST_HOLD : ST_REQ;
          end else if (branch_taken) begin
            drain_addr <= pc;
            pending_target <= target;
            state <= ST_DRAIN;
          end
        ST_HOLD: begin
          if (branch_taken) pc <= target;
          if (branch_taken || !stall) state <= ST_REQ;
        end
        ST_DRAIN:
          if (done) begin
            pc <= branch_taken ? target : pending_target;
            state <= ST_REQ;
          end else if (branch_taken) begin
            pending_target <= target;
          end
        default: state <= ST_REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vector table plus randomized run against a queue-based fetch model
module tb_if_fetch_unit;
  localparam logic [31:0] NOP_W = 32'h0000_0013;
  logic clk, reset, stall, branch_taken, imem_busywait, imem_read, if_valid;
  logic [31:0] branch_target, imem_address, imem_readdata, if_pc, if_instruction;
  int total, bad;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_read(imem_read), .imem_address(imem_address),
    .imem_readdata(imem_readdata), .imem_busywait(imem_busywait), .if_pc(if_pc),
    .if_instruction(if_instruction), .if_valid(if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, st, br, bw;
    logic [31:0] tgt;
    logic chk_rd, rd;
    logic [31:0] addr;
    logic v;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[$];

  typedef struct packed { logic [31:0] pc, instr; } ent_t;
  ent_t m_q[$];
  logic [31:0] m_pc, m_sq_addr, m_redir, e_pc, e_instr;
  logic m_sq, e_v;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0001;
  endfunction

  function automatic vec_t mk(input logic r, s, b, w, input logic [31:0] t,
                              input logic c, rd, input logic [31:0] a, input logic v, input logic [31:0] p);
    vec_t x;
    x.rst = r; x.st = s; x.br = b; x.bw = w; x.tgt = t;
    x.chk_rd = c; x.rd = rd; x.addr = a; x.v = v; x.pc = p;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, s, b, w, input logic [31:0] t);
    reset = r; stall = s; branch_taken = b; imem_busywait = w; branch_target = t;
    #1;
    imem_readdata = mem_word(imem_address);
  endtask

  // model: a word is either delivered, parked in a one-deep queue, or squashed by a redirect
  task automatic m_step(input logic r, s, b, w, input logic [31:0] t, input logic [31:0] data);
    logic rd, done, dv;
    logic [31:0] dpc, dins, tt;
    ent_t e;
    rd = m_q.size() == 0;
    done = rd && !w;
    dv = 1'b0; dpc = 0; dins = 0;
    tt = t & ~32'h3;
    if (r) begin
      m_q.delete(); m_sq = 0; m_pc = 32'h0;
      e_v = 0; e_pc = 0; e_instr = NOP_W;
      return;
    end
    if (m_sq) begin
      if (done) begin m_pc = b ? tt : m_redir; m_sq = 0; end
      else if (b) m_redir = tt;
    end else if (m_q.size() != 0) begin
      if (b) begin m_q.delete(); m_pc = tt; end
      else if (!s) begin e = m_q.pop_front(); dv = 1; dpc = e.pc; dins = e.instr; end
    end else if (done) begin
      if (b) m_pc = tt;
      else begin
        if (s) m_q.push_back({m_pc, data});
        else begin dv = 1; dpc = m_pc; dins = data; end
        m_pc = m_pc + 32'd4;
      end
    end else if (b) begin
      m_sq = 1; m_sq_addr = m_pc; m_redir = tt;
    end
    if (b || !s) begin
      e_v = dv; e_pc = dv ? dpc : 32'h0; e_instr = dv ? dins : NOP_W;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1; stall = 0; branch_taken = 0; imem_busywait = 0; branch_target = 0; imem_readdata = 0;
    // rst st br bw tgt | chk rd addr | v pc
    tbl.push_back(mk(1,0,0,0,0,            0,0,0,            0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h0,        1,32'h0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h4,        1,32'h4));
    tbl.push_back(mk(0,0,0,1,0,            1,1,32'h8,        0,0));
    tbl.push_back(mk(0,0,0,1,0,            1,1,32'h8,        0,0));
    tbl.push_back(mk(0,0,0,1,0,            1,1,32'h8,        0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h8,        1,32'h8));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'hC,        1,32'hC));
    tbl.push_back(mk(0,1,0,0,0,            1,1,32'h10,       1,32'hC));
    tbl.push_back(mk(0,1,0,0,0,            1,0,0,            1,32'hC));
    tbl.push_back(mk(0,1,0,0,0,            1,0,0,            1,32'hC));
    tbl.push_back(mk(0,1,0,0,0,            1,0,0,            1,32'hC));
    tbl.push_back(mk(0,0,0,0,0,            1,0,0,            1,32'h10));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h14,       1,32'h14));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h18,       1,32'h18));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h1C,       1,32'h1C));
    tbl.push_back(mk(0,0,1,1,32'h100,      1,1,32'h20,       0,0));
    tbl.push_back(mk(0,0,0,1,0,            1,1,32'h20,       0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h20,       0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h100,      1,32'h100));
    tbl.push_back(mk(0,0,1,0,32'h30,       1,1,32'h104,      0,0));
    tbl.push_back(mk(0,1,0,0,0,            1,1,32'h30,       0,0));
    tbl.push_back(mk(0,1,1,0,32'h200,      1,0,0,            0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h200,      1,32'h200));
    tbl.push_back(mk(0,0,1,0,32'h40,       1,1,32'h204,      0,0));
    tbl.push_back(mk(0,0,0,1,0,            1,1,32'h40,       0,0));
    tbl.push_back(mk(1,0,0,1,0,            1,1,32'h40,       0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h0,        1,32'h0));
    tbl.push_back(mk(0,0,1,0,32'hFFFF_FFFC,1,1,32'h4,        0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'hFFFF_FFFC,1,32'hFFFF_FFFC));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h0,        1,32'h0));
    tbl.push_back(mk(0,1,0,1,0,            1,1,32'h4,        1,32'h0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h4,        1,32'h4));
    tbl.push_back(mk(0,0,1,1,32'h300,      1,1,32'h8,        0,0));
    tbl.push_back(mk(0,0,1,1,32'h400,      1,1,32'h8,        0,0));
    tbl.push_back(mk(0,1,0,0,0,            1,1,32'h8,        0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h400,      1,32'h400));
    tbl.push_back(mk(0,0,1,1,32'h500,      1,1,32'h404,      0,0));
    tbl.push_back(mk(0,0,1,0,32'h600,      1,1,32'h404,      0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,1,32'h600,      1,32'h600));
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].br, tbl[i].bw, tbl[i].tgt);
      if (tbl[i].chk_rd) begin
        chk($sformatf("vec%0d imem_read", i), {31'b0, imem_read}, {31'b0, tbl[i].rd});
        if (tbl[i].rd) chk($sformatf("vec%0d imem_address", i), imem_address, tbl[i].addr);
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].v});
      chk($sformatf("vec%0d if_pc", i), if_pc, tbl[i].pc);
      chk($sformatf("vec%0d if_instruction", i), if_instruction, tbl[i].v ? mem_word(tbl[i].pc) : NOP_W);
    end
    drive(1, 0, 0, 0, 0);
    m_step(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int n = 0; n < 3000; n++) begin
      logic r, s, b, w, erd;
      logic [31:0] t, eaddr;
      r = $urandom_range(199) == 0;
      s = $urandom_range(3) == 0;
      b = $urandom_range(7) == 0;
      w = $urandom_range(2) == 0;
      t = $urandom & ~32'h3;
      if ($urandom_range(15) == 0) t = 32'hFFFF_FFF8;
      drive(r, s, b, w, t);
      erd = m_q.size() == 0;
      eaddr = m_sq ? m_sq_addr : m_pc;
      chk("rnd imem_read", {31'b0, imem_read}, {31'b0, erd});
      if (erd) chk("rnd imem_address", imem_address, eaddr);
      m_step(r, s, b, w, t, imem_readdata);
      @(posedge clk); #1;
      chk("rnd if_valid", {31'b0, if_valid}, {31'b0, e_v});
      chk("rnd if_pc", if_pc, e_pc);
      chk("rnd if_instruction", if_instruction, e_instr);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
